// File: rtl/boardman_wb_master_if.sv
// Classic Wishbone bus between the board-manager initiator
// and the internal 25-bit register bus.
interface boardman_wb_master_if #(
   parameter int ADR_WIDTH = 25
);
   logic                 wb_cyc_o;
   logic                 wb_stb_o;
   logic                 wb_we_o;
   logic [ADR_WIDTH-1:0] wb_adr_o;
   logic [31:0]          wb_dat_o;
   logic [3:0]           wb_sel_o;
   logic [31:0]          wb_dat_i;
   logic                 wb_ack_i;
   logic                 wb_err_i;
   logic                 wb_rty_i;

   modport master (
      output wb_cyc_o, wb_stb_o, wb_we_o,
      output wb_adr_o, wb_dat_o, wb_sel_o,
      input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
   );

   modport slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o,
      input  wb_adr_o, wb_dat_o, wb_sel_o,
      output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
   );
endinterface

// File: rtl/boardman_wb_master.sv
// Board-manager Wishbone initiator: runs decoded commands as
// single or burst classic cycles with one idle cycle per beat.
module boardman_wb_master #(
   parameter int TIMEOUT   = 255,
   parameter int ADR_WIDTH = 25
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [22:0] cmd_adr_i,
   input  logic        cmd_we_i,
   input  logic [1:0]  burst_size_i,
   input  logic [3:0]  upper_addr_i,
   input  logic [31:0] wdat_i,
   input  logic        wdat_valid_i,
   output logic        wdat_ready_o,
   output logic [31:0] rdat_o,
   output logic        rdat_valid_o,
   input  logic        rdat_ready_i,
   output logic        done_o,
   output logic        done_err_o,
   output logic [4:0]  done_beats_o,
   boardman_wb_master_if.master wb
);

   typedef enum logic [2:0] {
      S_IDLE, S_WDATA, S_BUS, S_GAP, S_RDATA, S_DONE
   } state_e;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_e               state_q, state_d;
   logic                 we_q, we_d;
   logic [ADR_WIDTH-1:0] adr_q, adr_d;
   logic [31:0]          dat_q, dat_d;
   logic [31:0]          rdat_q, rdat_d;
   logic                 rvld_q, rvld_d;
   logic                 bus_q, bus_d;
   logic [4:0]           tot_q, tot_d;
   logic [4:0]           cnt_q, cnt_d;
   logic [15:0]          tmo_q, tmo_d;
   logic                 err_q, err_d;
   logic                 done_q, done_d;
   logic                 wdat_rdy;
   logic [4:0]           cnt_inc;
   logic                 unused_adr_lsb;

   assign cnt_inc        = cnt_q + 5'd1;
   assign unused_adr_lsb = ^cmd_adr_i[1:0];

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      rdat_d   = rdat_q;
      rvld_d   = rvld_q;
      bus_d    = bus_q;
      tot_d    = tot_q;
      cnt_d    = cnt_q;
      tmo_d    = tmo_q;
      err_d    = err_q;
      done_d   = 1'b0;
      wdat_rdy = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               we_d  = cmd_we_i;
               adr_d = {cmd_adr_i[21] ? upper_addr_i : 4'h0,
                        cmd_adr_i[20:2], 2'b00};
               tot_d = cmd_adr_i[22] ?
                       5'(5'd2 << burst_size_i) : 5'd1;
               cnt_d = 5'd0;
               err_d = 1'b0;
               if (cmd_we_i) begin
                  state_d = S_WDATA;
               end else begin
                  state_d = S_BUS;
                  bus_d   = 1'b1;
                  tmo_d   = 16'd0;
               end
            end
         end
         S_WDATA: begin
            if (wdat_valid_i) begin
               wdat_rdy = 1'b1;
               dat_d    = wdat_i;
               state_d  = S_BUS;
               bus_d    = 1'b1;
               tmo_d    = 16'd0;
            end
         end
         S_BUS: begin
            // err beats rty beats ack; a same-cycle ack beats timeout
            if (wb.wb_err_i || wb.wb_rty_i) begin
               err_d   = 1'b1;
               bus_d   = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (wb.wb_ack_i) begin
               bus_d = 1'b0;
               if (we_q) begin
                  state_d = S_GAP;
               end else begin
                  rdat_d  = wb.wb_dat_i;
                  rvld_d  = 1'b1;
                  state_d = S_RDATA;
               end
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               bus_d   = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_RDATA: begin
            if (rdat_ready_i) begin
               rvld_d  = 1'b0;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            cnt_d = cnt_inc;
            adr_d = adr_q + ADR_WIDTH'(4);
            if (cnt_inc == tot_q) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (!we_q) begin
               bus_d   = 1'b1;
               tmo_d   = 16'd0;
               state_d = S_BUS;
            end else if (wdat_valid_i) begin
               // ready data skips WDATA so stb returns after one idle cycle
               wdat_rdy = 1'b1;
               dat_d    = wdat_i;
               bus_d    = 1'b1;
               tmo_d    = 16'd0;
               state_d  = S_BUS;
            end else begin
               state_d = S_WDATA;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         rdat_q  <= '0;
         rvld_q  <= 1'b0;
         bus_q   <= 1'b0;
         tot_q   <= '0;
         cnt_q   <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         rdat_q  <= rdat_d;
         rvld_q  <= rvld_d;
         bus_q   <= bus_d;
         tot_q   <= tot_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign cmd_ready_o  = (state_q == S_IDLE) && !wb_rst_i;
   assign wdat_ready_o = wdat_rdy;
   assign rdat_o       = rdat_q;
   assign rdat_valid_o = rvld_q;
   assign done_o       = done_q;
   assign done_err_o   = err_q;
   assign done_beats_o = cnt_q;
   assign wb.wb_cyc_o  = bus_q;
   assign wb.wb_stb_o  = bus_q;
   assign wb.wb_we_o   = we_q;
   assign wb.wb_adr_o  = adr_q;
   assign wb.wb_dat_o  = dat_q;
   assign wb.wb_sel_o  = 4'hF;

endmodule

// File: doc/boardman_wb_master.md
# boardman_wb_master

Wishbone initiator for the debug board-manager path. It takes decoded access commands from the board-manager command decoder and runs them as classic Wishbone cycles on the internal 25-bit register bus, including the ID/control space and its clock monitors. Burst length and upper address bits come from the ID/control block's `burst_size_o` and `upper_addr_o`. Read data, write-data consumption and per-command completion status go back to the command decoder.

## Interface
Parameters:
- `TIMEOUT`, 255: wb_clk cycles a beat waits for ack/err/rty before it is aborted. Legal range 1 to 65535.
- `ADR_WIDTH`, 25: width of the Wishbone byte address. Fixed at 25: 4 upper bits plus 21 lower bits.

Ports:
- `wb_clk_i`  in  1: the single clock.
- `wb_rst_i`  in  1: asynchronous, active-high reset.
- `cmd_valid_i`  in  1: command valid.
- `cmd_ready_o`  out  1: command accepted when high together with `cmd_valid_i`.
- `cmd_adr_i`  in  23: command address. Bit 22 = burst, bit 21 = use upper address, [20:0] = byte address (bits [1:0] are ignored).
- `cmd_we_i`  in  1: 1 = write, 0 = read.
- `burst_size_i`  in  2: burst length code, sampled at command accept.
- `upper_addr_i`  in  4: upper address bits, sampled at command accept.
- `wdat_i`  in  32: write data.
- `wdat_valid_i`  in  1: write data valid.
- `wdat_ready_o`  out  1: write data consumed this cycle.
- `rdat_o`  out  32: read data.
- `rdat_valid_o`  out  1: read data valid.
- `rdat_ready_i`  in  1: read data taken.
- `done_o`  out  1: one-cycle pulse at command end.
- `done_err_o`  out  1: with `done_o`, 1 = the command terminated by err, rty or timeout.
- `done_beats_o`  out  5: with `done_o`, number of beats completed successfully.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each: Wishbone controls.
- `wb_adr_o`  out  25: Wishbone address.
- `wb_dat_o`  out  32: Wishbone write data.
- `wb_sel_o`  out  4: byte selects, constant 4'hF.
- `wb_dat_i`  in  32: Wishbone read data.
- `wb_ack_i`, `wb_err_i`, `wb_rty_i`  in  1 each: Wishbone terminations.

## Operation
- States: IDLE, WDATA, BUS, GAP, RDATA, DONE.
- IDLE
  - `cmd_ready_o` = 1 while `wb_rst_i` is low; it is 0 in every other state and during reset.
  - On accept, latch `cmd_we_i` and the base address. Base address = {bit21 ? `upper_addr_i` : 4'h0, `cmd_adr_i`[20:2], 2'b00}.
  - Beat count = bit22 ? 2^(`burst_size_i`+1) : 1, i.e. 2, 4, 8 or 16 beats.
  - Next state: WDATA for a write, BUS for a read.
- WDATA: wait for `wdat_valid_i`. When it is high, `wdat_ready_o` = 1 for that cycle, `wb_dat_o` is loaded, and the state moves to BUS.
- BUS
  - `wb_cyc_o` = `wb_stb_o` = 1; `wb_we_o` = the latched write flag; `wb_adr_o` = base + 4×beat index.
  - Termination priority: err > rty > ack > timeout.
  - ack, write: go to GAP.
  - ack, read: capture `wb_dat_i` into `rdat_o` and go to RDATA.
  - err, rty or timeout: set the error flag and go to DONE. Remaining beats are skipped, and their write data is NOT consumed.
- RDATA: `rdat_valid_o` = 1 until `rdat_ready_i` is seen, then go to GAP. The bus stays idle while read data is stalled.
- GAP
  - Exactly one cycle with cyc and stb low; targets require stb to drop between beats.
  - Increment the completed-beat count.
  - If the count equals the beat total, go to DONE; otherwise go to WDATA (write) or BUS (read).
- DONE: `done_o` = 1 for one cycle with `done_err_o` and `done_beats_o` valid, then go to IDLE.
- Address arithmetic wraps at 25 bits with no carry detection.
- `rdat_o` holds its last value when `rdat_valid_o` is low.

## Timing
- Reset value of every output is 0, including `wb_adr_o`, `wb_dat_o` and `rdat_o`. The exception is `wb_sel_o` = 4'hF.
- Reset asserted mid-cycle: cyc, stb and all valid/ready outputs drop asynchronously. The state returns to IDLE and the command in progress is lost with no `done_o`.
- Accept (cycle N) → `wb_stb_o` high:
  - read: at N+1;
  - write with data already valid: WDATA at N+1, stb at N+2.
- Ack at cycle M, read: `rdat_valid_o` rises at M+1. The next stb can rise no earlier than 2 cycles after `rdat_ready_i`: one cycle in GAP, then BUS.
- Ack at cycle M, write: stb is low at M+1 (GAP) and high again at M+2 (or later, if write data is stalled).
- Timeout counter:
  - Clears on entry to BUS and increments every BUS cycle.
  - When it reaches `TIMEOUT` with no termination, the beat aborts and cyc drops the next cycle.
  - A termination in the same cycle as the timeout wins.
- Back-to-back commands: the earliest next accept is the cycle after DONE.

## Test plan
- Single write. Command adr 0x000010, we=1, `wdat_i` 0xDEADBEEF already valid, target acks 2 cycles after stb → one cycle with `wb_adr_o`=0x0000010, `wb_we_o`=1, `wb_dat_o`=0xDEADBEEF; `done_o` with err=0 and beats=1.
- Burst read. bit22=1, `burst_size_i`=1, adr 0x40 → 4 stb pulses at 0x40, 0x44, 0x48, 0x4C, with stb low ≥1 cycle between them. Holding `rdat_ready_i` low for 3 cycles on beat 2 produces no stb during the stall. Data is returned in order; done reports beats=4.
- Upper address. `upper_addr_i`=4'hA, bit21=1, adr 0x1234 → `wb_adr_o`=0x1401234. The same command with bit21=0 → 0x0001234.
- Timeout. `TIMEOUT`=16, target never terminates → stb high for exactly 16 cycles, then cyc low; done with err=1 and beats=0.
- Error mid-burst. 8-beat write burst, `wb_err_i` on beat 3 → bus activity ends; `wdat_ready_o` pulsed exactly 3 times; done with err=1 and beats=2. Repeat with `wb_rty_i` for the same result.
- Reset mid-burst. Assert `wb_rst_i` during beat 2 of a read burst → `wb_cyc_o`, `wb_stb_o` and `rdat_valid_o` are 0 the same cycle with no clock edge required; no `done_o`; `cmd_ready_o`=1 the first cycle after release.
